skeleton_pass_sequencer: RTL and testbench

- Sequences the bank of kernel RAM convolution units over an N x N image held in a single-port frame RAM.
- Each pass has two phases:
  - LOAD: streams every pixel into the kernel units.
  - READOUT: sweeps addresses with write disabled, collects each unit's result and writes it back to the frame RAM.
- Passes repeat until a pass changes no pixel or MAX_PASSES is reached, then done is signalled.
- Sits between the top-level start/done control and the kernel unit array.

---
 rtl/skel_pkg.sv | 20 ++
 rtl/scan_addr_gen.sv | 55 +++++
 rtl/skeleton_pass_sequencer.sv | 130 +++++++++++++
 tb/tb_skeleton_pass_sequencer.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/skel_pkg.sv
// Shared types and default geometry for the skeletonization pass sequencer.
package skel_pkg;
    localparam int N_DEFAULT           = 8;
    localparam int BIT_SIZE_DEFAULT    = 6;
    localparam int PIXEL_WIDTH_DEFAULT = 8;
    localparam int MAX_PASSES_DEFAULT  = 16;

    localparam int ADDR_W      = BIT_SIZE_DEFAULT + 1;
    localparam int IMG_PIXELS  = N_DEFAULT * N_DEFAULT;
    localparam int SLOT_CYCLES = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        GAP,
        READOUT,
        CHECK,
        FIN
    } seq_state_t;
endpackage

// File: rtl/scan_addr_gen.sv
// Slot-phase counter plus pixel address counter; the address advances once per
// slot and saturates at the last pixel so a phase never wraps.
module scan_addr_gen
    import skel_pkg::*;
#(
    parameter int PIXELS = IMG_PIXELS,
    parameter int AW     = ADDR_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          enable,
    output logic [AW-1:0] addr,
    output logic          slot_phase,
    output logic          last
);
    localparam int SLOT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [SLOT_W-1:0] SLOT_END = SLOT_W'(SLOT_CYCLES - 1);
    localparam logic [AW-1:0]     ADDR_END = AW'(PIXELS - 1);

    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [AW-1:0]     addr_q, addr_d;

    always_comb begin
        slot_d = slot_q;
        addr_d = addr_q;
        if (clear) begin
            slot_d = '0;
            addr_d = '0;
        end else if (enable) begin
            if (slot_q == SLOT_END) begin
                slot_d = '0;
                if (addr_q != ADDR_END) begin
                    addr_d = addr_q + 1'b1;
                end
            end else begin
                slot_d = slot_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= '0;
            addr_q <= '0;
        end else begin
            slot_q <= slot_d;
            addr_q <= addr_d;
        end
    end

    assign addr       = addr_q;
    assign slot_phase = (slot_q == SLOT_END);
    assign last       = (addr_q == ADDR_END);
endmodule

// File: rtl/skeleton_pass_sequencer.sv
// Runs LOAD / GAP / READOUT passes of the kernel-unit array over the frame RAM
// until a pass changes nothing or the pass limit is hit.
module skeleton_pass_sequencer
    import skel_pkg::*;
#(
    parameter int  N           = N_DEFAULT,
    parameter int  BIT_SIZE    = BIT_SIZE_DEFAULT,
    parameter int  PIXEL_WIDTH = PIXEL_WIDTH_DEFAULT,
    parameter int  MAX_PASSES  = MAX_PASSES_DEFAULT,
    localparam int CNT_W       = $clog2(MAX_PASSES + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_W-1:0]       pass_count,
    output logic [BIT_SIZE:0]      frame_addr,
    input  logic [PIXEL_WIDTH-1:0] frame_rdata,
    output logic                   frame_we,
    output logic [PIXEL_WIDTH-1:0] frame_wdata,
    output logic                   k_we,
    output logic [BIT_SIZE:0]      k_addr,
    output logic [PIXEL_WIDTH-1:0] k_data,
    input  logic [PIXEL_WIDTH-1:0] k_result
);
    localparam int AW     = BIT_SIZE + 1;
    localparam int PIXELS = N * N;

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] pass_q, pass_d, pass_inc;
    logic             changed_q, changed_d;

    logic          scan_clear, scan_enable, slot_phase, last;
    logic [AW-1:0] scan_addr;

    scan_addr_gen #(
        .PIXELS (PIXELS),
        .AW     (AW)
    ) u_scan (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (scan_clear),
        .enable     (scan_enable),
        .addr       (scan_addr),
        .slot_phase (slot_phase),
        .last       (last)
    );

    assign pass_inc = pass_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        pass_d    = pass_q;
        changed_d = changed_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = LOAD;
                    pass_d    = '0;
                    changed_d = 1'b0;
                end
            end
            LOAD:    if (slot_phase && last) state_d = GAP;
            GAP:     if (slot_phase) state_d = READOUT;
            READOUT: begin
                if (slot_phase && (k_result != frame_rdata)) changed_d = 1'b1;
                if (slot_phase && last) state_d = CHECK;
            end
            CHECK: begin
                pass_d = pass_inc;
                if (changed_q && (pass_inc < CNT_W'(MAX_PASSES))) begin
                    changed_d = 1'b0;
                    state_d   = LOAD;
                end else begin
                    state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Restart the slot/address counter at every phase boundary.
        scan_enable = (state_q == LOAD) || (state_q == GAP) || (state_q == READOUT);
        scan_clear  = !scan_enable || (state_d != state_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pass_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pass_q    <= pass_d;
            changed_q <= changed_d;
        end
    end

    // LOAD re-reads the next pixel in s1, so frame_rdata (and k_data) already
    // holds pixel a throughout both cycles of slot a; quiet states park on 0.
    always_comb begin
        busy        = (state_q != IDLE);
        done        = (state_q == FIN);
        frame_addr  = '0;
        frame_we    = 1'b0;
        frame_wdata = '0;
        k_we        = 1'b0;
        k_addr      = '0;
        k_data      = '0;
        case (state_q)
            LOAD: begin
                frame_addr = (slot_phase && !last) ? scan_addr + 1'b1 : scan_addr;
                k_we       = 1'b1;
                k_addr     = scan_addr;
                k_data     = frame_rdata;
            end
            READOUT: begin
                frame_addr = scan_addr;
                k_addr     = scan_addr;
                if (slot_phase) begin
                    frame_we    = 1'b1;
                    frame_wdata = k_result;
                end
            end
            default: ;
        endcase
    end

    assign pass_count = pass_q;
endmodule

// File: tb/tb_skeleton_pass_sequencer.sv
// Directed bench: two sequencers (MAX_PASSES 16 and 3) each with a frame RAM and kernel model.
module tb_skeleton_pass_sequencer;
    localparam int NP = 64;
    localparam int TR = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start [2];
    logic       busy_w [2];
    logic       done_w [2];
    logic [4:0] pc0;
    logic [1:0] pc1;
    logic [6:0] faddr [2];
    logic [7:0] frdata [2];
    logic       fwe [2];
    logic [7:0] fwdata [2];
    logic       kwe [2];
    logic [6:0] kaddr [2];
    logic [7:0] kdata [2];
    logic [7:0] kres [2];

    skeleton_pass_sequencer #(.N(8), .BIT_SIZE(6), .PIXEL_WIDTH(8), .MAX_PASSES(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .busy(busy_w[0]), .done(done_w[0]),
        .pass_count(pc0), .frame_addr(faddr[0]), .frame_rdata(frdata[0]), .frame_we(fwe[0]),
        .frame_wdata(fwdata[0]), .k_we(kwe[0]), .k_addr(kaddr[0]), .k_data(kdata[0]),
        .k_result(kres[0]));

    skeleton_pass_sequencer #(.N(8), .BIT_SIZE(6), .PIXEL_WIDTH(8), .MAX_PASSES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .busy(busy_w[1]), .done(done_w[1]),
        .pass_count(pc1), .frame_addr(faddr[1]), .frame_rdata(frdata[1]), .frame_we(fwe[1]),
        .frame_wdata(fwdata[1]), .k_we(kwe[1]), .k_addr(kaddr[1]), .k_data(kdata[1]),
        .k_result(kres[1]));

    // Frame RAM and kernel-array models
    logic [7:0] fmem [2][NP];
    logic [7:0] kmem [2][NP];
    logic [7:0] exp_img [2][NP];
    int         acc_per [2][NP];
    int         we_total [2];
    logic       kph [2];
    logic       phase_sel [2];
    int         mode [2];
    logic       ld_en;
    int         ld_g;
    logic [5:0] ld_addr;
    logic [7:0] ld_data;

    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (!rst_n) begin
                kph[g]      <= 1'b0;
                we_total[g] <= 0;
                for (int a = 0; a < NP; a++) acc_per[g][a] <= 0;
            end else begin
                kph[g] <= ~kph[g];
                if (fwe[g]) begin
                    fmem[g][faddr[g][5:0]] <= fwdata[g];
                    we_total[g] <= we_total[g] + 1;
                end
                if (kwe[g] && (kph[g] == phase_sel[g])) begin
                    kmem[g][kaddr[g][5:0]]    <= kdata[g];
                    acc_per[g][kaddr[g][5:0]] <= acc_per[g][kaddr[g][5:0]] + 1;
                end
            end
            if (ld_en && ld_g == g) fmem[g][ld_addr] <= ld_data;
            frdata[g] <= fmem[g][faddr[g][5:0]];
        end
    end

    // mode 0 identity, 1 clears a set pixel 27, 2 inverts every pixel
    logic [7:0] kv [2];
    always_comb begin
        for (int g = 0; g < 2; g++) begin
            kv[g]   = kmem[g][kaddr[g][5:0]];
            kres[g] = kv[g];
            if (mode[g] == 1 && kaddr[g] == 7'd27 && kv[g] != 8'd0) kres[g] = 8'd0;
            if (mode[g] == 2) kres[g] = ~kv[g];
        end
    end

    // Kernel-side protocol monitor: every LOAD value must stay for exactly 2 cycles.
    int         hold_bad [2];
    int         run_len [2];
    logic       prev_we [2];
    logic [6:0] prev_addr [2];
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (!rst_n) begin
                hold_bad[g] <= 0;
                run_len[g]  <= 0;
                prev_we[g]  <= 1'b0;
                prev_addr[g] <= '0;
            end else begin
                if (kwe[g]) begin
                    if (prev_we[g] && kaddr[g] == prev_addr[g]) begin
                        run_len[g] <= run_len[g] + 1;
                    end else begin
                        if (prev_we[g] && run_len[g] != 2) hold_bad[g] <= hold_bad[g] + 1;
                        run_len[g] <= 1;
                    end
                end else if (prev_we[g] && run_len[g] != 2) begin
                    hold_bad[g] <= hold_bad[g] + 1;
                end
                if (faddr[g] > 7'd63 || kaddr[g] > 7'd63) hold_bad[g] <= hold_bad[g] + 1;
                prev_we[g]   <= kwe[g];
                prev_addr[g] <= kaddr[g];
            end
        end
    end

    int         total = 0;
    int         bad = 0;
    logic       tr_kwe [TR];
    logic [6:0] tr_kaddr [TR];
    logic       tr_fwe [TR];
    logic [6:0] tr_faddr [TR];
    int         tr_pc [TR];

    task automatic load_image(input int g, input int kind);
        for (int a = 0; a < NP; a++) begin
            @(negedge clk);
            ld_en   = 1'b1;
            ld_g    = g;
            ld_addr = 6'(a);
            ld_data = (kind == 0) ? ((a == 27) ? 8'h01 : 8'h00) : 8'((a * 7 + 3) & 255);
            exp_img[g][a] = ld_data;
        end
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // Cycle 1 is the first cycle after the edge that samples start.
    task automatic run(input int g, input int budget, input int pulse_at, output int done_cyc);
        int cyc;
        done_cyc = -1;
        cyc = 0;
        start[g] = 1'b1;
        while (cyc < budget && done_cyc < 0) begin
            @(negedge clk);
            cyc++;
            start[g] = (cyc == pulse_at);
            if (cyc < TR) begin
                tr_kwe[cyc]   = kwe[g];
                tr_kaddr[cyc] = kaddr[g];
                tr_fwe[cyc]   = fwe[g];
                tr_faddr[cyc] = faddr[g];
                tr_pc[cyc]    = (g == 0) ? int'(pc0) : int'(pc1);
            end
            if (done_w[g]) done_cyc = cyc;
        end
    endtask

    function automatic int frame_diffs(input int g, input int skip);
        int n = 0;
        for (int a = 0; a < NP; a++)
            if (a != skip && fmem[g][a] !== exp_img[g][a]) n++;
        return n;
    endfunction

    task automatic test_reset();
        int found, nd, dc;
        logic [39:0] outs;
        outs = {busy_w[0], done_w[0], pc0, faddr[0], fwe[0], fwdata[0], kwe[0], kaddr[0], kdata[0]};
        total++;
        if (outs !== '0) begin bad++; $display("FAIL reset_idle: got %h want 0", outs); end
        load_image(0, 0);
        mode[0] = 0;
        start[0] = 1'b1;
        found = 0;
        for (int c = 0; c < 200 && found == 0; c++) begin
            @(negedge clk);
            start[0] = 1'b0;
            if (kwe[0] && kaddr[0] == 7'd20) found = 1;
        end
        total++;
        if (found != 1) begin bad++; $display("FAIL reach_addr20: got %0d want 1", found); end
        rst_n = 1'b0;
        #1;
        outs = {busy_w[0], done_w[0], pc0, faddr[0], fwe[0], fwdata[0], kwe[0], kaddr[0], kdata[0]};
        total++;
        if (outs !== '0) begin bad++; $display("FAIL reset_midload: got %h want 0", outs); end
        nd = 0;
        repeat (3) begin
            @(negedge clk);
            if (done_w[0] !== 1'b0) nd++;
        end
        total++;
        if (nd != 0) begin bad++; $display("FAIL reset_no_done: got %0d want 0", nd); end
        rst_n = 1'b1;
        @(negedge clk);
        run(0, 400, -1, dc);
        total++;
        if (dc != 260) begin bad++; $display("FAIL restart_done_cycle: got %0d want 260", dc); end
        total++;
        if (tr_kaddr[1] !== 7'd0 || tr_faddr[1] !== 7'd0 || tr_kwe[1] !== 1'b1 || tr_pc[1] != 0) begin
            bad++;
            $display("FAIL restart_first_cycle: got kaddr=%0d faddr=%0d kwe=%0b pc=%0d want 0 0 1 0",
                     tr_kaddr[1], tr_faddr[1], tr_kwe[1], tr_pc[1]);
        end
    endtask

    task automatic test_single_pass();
        int dc, w0, d;
        load_image(0, 0);
        mode[0] = 0;
        w0 = we_total[0];
        run(0, 400, -1, dc);
        total++;
        if (dc != 260) begin bad++; $display("FAIL single_done_cycle: got %0d want 260", dc); end
        total++;
        if (pc0 !== 5'd1) begin bad++; $display("FAIL single_pass_count: got %0d want 1", pc0); end
        @(negedge clk);
        total++;
        if (we_total[0] - w0 != 64) begin bad++; $display("FAIL single_we_count: got %0d want 64", we_total[0] - w0); end
        d = frame_diffs(0, -1);
        total++;
        if (d != 0) begin bad++; $display("FAIL single_frame: got %0d diffs want 0", d); end
        total++;
        if (done_w[0] !== 1'b0 || busy_w[0] !== 1'b0) begin
            bad++;
            $display("FAIL single_after_fin: got done=%0b busy=%0b want 0 0", done_w[0], busy_w[0]);
        end
    endtask

    task automatic test_two_pass();
        int dc, w0, d;
        load_image(0, 0);
        mode[0] = 1;
        w0 = we_total[0];
        run(0, 700, -1, dc);
        @(negedge clk);
        total++;
        if (dc != 519) begin bad++; $display("FAIL two_done_cycle: got %0d want 519", dc); end
        total++;
        if (pc0 !== 5'd2) begin bad++; $display("FAIL two_pass_count: got %0d want 2", pc0); end
        total++;
        if (fmem[0][27] !== 8'h00) begin bad++; $display("FAIL two_pixel27: got %h want 00", fmem[0][27]); end
        d = frame_diffs(0, 27);
        total++;
        if (d != 0) begin bad++; $display("FAIL two_frame_rest: got %0d diffs want 0", d); end
        total++;
        if (we_total[0] - w0 != 128) begin bad++; $display("FAIL two_we_count: got %0d want 128", we_total[0] - w0); end
        mode[0] = 0;
    endtask

    task automatic test_max_passes();
        int dc, w0;
        load_image(1, 1);
        mode[1] = 2;
        phase_sel[1] = 1'b1;
        w0 = we_total[1];
        run(1, 1000, -1, dc);
        @(negedge clk);
        total++;
        if (dc != 778) begin bad++; $display("FAIL max_done_cycle: got %0d want 778", dc); end
        total++;
        if (pc1 !== 2'd3) begin bad++; $display("FAIL max_pass_count: got %0d want 3", pc1); end
        total++;
        if (we_total[1] - w0 != 192) begin bad++; $display("FAIL max_we_count: got %0d want 192", we_total[1] - w0); end
        total++;
        if (fmem[1][5] !== ~exp_img[1][5]) begin
            bad++;
            $display("FAIL max_pixel5: got %h want %h", fmem[1][5], ~exp_img[1][5]);
        end
    endtask

    task automatic test_protocol();
        int dc, h0, nacc, nk;
        int snap [NP];
        load_image(0, 1);
        mode[0] = 0;
        for (int ph = 0; ph < 2; ph++) begin
            phase_sel[0] = ph[0];
            @(negedge clk);
            for (int a = 0; a < NP; a++) snap[a] = acc_per[0][a];
            h0 = hold_bad[0];
            run(0, 400, -1, dc);
            @(negedge clk);
            total++;
            if (hold_bad[0] - h0 != 0) begin bad++; $display("FAIL proto_hold ph%0d: got %0d bad holds want 0", ph, hold_bad[0] - h0); end
            nacc = 0;
            nk = 0;
            for (int a = 0; a < NP; a++) begin
                if (acc_per[0][a] - snap[a] != 1) nacc++;
                if (kmem[0][a] !== exp_img[0][a]) nk++;
            end
            total++;
            if (nacc != 0) begin bad++; $display("FAIL proto_once ph%0d: got %0d addrs not accepted once want 0", ph, nacc); end
            total++;
            if (nk != 0) begin bad++; $display("FAIL proto_kdata ph%0d: got %0d wrong pixels want 0", ph, nk); end
            total++;
            if (tr_kwe[128] !== 1'b1 || tr_kaddr[128] !== 7'd63) begin
                bad++;
                $display("FAIL proto_load_last ph%0d: got kwe=%0b kaddr=%0d want 1 63", ph, tr_kwe[128], tr_kaddr[128]);
            end
            total++;
            if ({tr_kwe[129], tr_kwe[130], tr_kaddr[129], tr_kaddr[130], tr_fwe[129], tr_fwe[130]} !== '0) begin
                bad++;
                $display("FAIL proto_gap ph%0d: got kwe=%0b%0b kaddr=%0d,%0d want 00 0,0",
                         ph, tr_kwe[129], tr_kwe[130], tr_kaddr[129], tr_kaddr[130]);
            end
            total++;
            if (tr_fwe[131] !== 1'b0 || tr_fwe[132] !== 1'b1 || tr_fwe[258] !== 1'b1 || tr_fwe[259] !== 1'b0) begin
                bad++;
                $display("FAIL proto_readout_we ph%0d: got %0b%0b%0b%0b want 0110", ph,
                         tr_fwe[131], tr_fwe[132], tr_fwe[258], tr_fwe[259]);
            end
        end
        phase_sel[0] = 1'b0;
    endtask

    task automatic test_start_during_readout();
        int dc;
        load_image(0, 0);
        mode[0] = 0;
        run(0, 400, 150, dc);
        total++;
        if (dc != 260) begin bad++; $display("FAIL busy_start_done_cycle: got %0d want 260", dc); end
        total++;
        if (pc0 !== 5'd1) begin bad++; $display("FAIL busy_start_pass_count: got %0d want 1", pc0); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int dc;
        load_image(0, 0);
        mode[0] = 0;
        run(0, 400, 260, dc);
        total++;
        if (dc != 260) begin bad++; $display("FAIL b2b_first_done: got %0d want 260", dc); end
        @(negedge clk);
        start[0] = 1'b0;
        total++;
        if (busy_w[0] !== 1'b0) begin bad++; $display("FAIL b2b_fin_start_ignored: got busy=%0b want 0", busy_w[0]); end
        run(0, 400, -1, dc);
        total++;
        if (dc != 260) begin bad++; $display("FAIL b2b_second_done: got %0d want 260", dc); end
        total++;
        if (tr_pc[2] != 0 || pc0 !== 5'd1) begin
            bad++;
            $display("FAIL b2b_pass_count: got start=%0d end=%0d want 0 1", tr_pc[2], pc0);
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        start[0] = 1'b0;
        start[1] = 1'b0;
        ld_en = 1'b0;
        ld_g = 0;
        ld_addr = '0;
        ld_data = '0;
        mode[0] = 0;
        mode[1] = 0;
        phase_sel[0] = 1'b0;
        phase_sel[1] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_single_pass();
        test_two_pass();
        test_max_passes();
        test_protocol();
        test_start_during_readout();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
